// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin arbiter sharing one single-port frame BRAM between two requesters.
// Optional BRAM_ARB_STATS_EN adds grant/stall counters. Rev 1.0
`default_nettype none

module bram_arbiter #(
   parameter int ADDR_W    = 19,
   parameter int DATA_W    = 8,
   parameter int RD_LAT    = 2,
   parameter int MAX_BURST = 540
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_gnt_o,
   output logic              m0_rvalid_o,
   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_gnt_o,
   output logic              m1_rvalid_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              ena_o,
   output logic              wea_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] dina_o,
   input  logic [DATA_W-1:0] douta_i,
   output logic              busy_o,
   output logic [31:0]       m0_gcnt_o,
   output logic [31:0]       m1_gcnt_o,
   output logic [31:0]       stall_cnt_o
);

   localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
   localparam logic [CNT_W-1:0] BURST_ONE  = (MAX_BURST > 1) ? CNT_W'(1) : CNT_W'(0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   burst_q, burst_d;
   logic               last_q, last_d;
   logic               gnt0, gnt1;
   logic               ena_q, wea_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  dina_q, rdata_q;
   logic [RD_LAT:0]    tag_v_q, tag_id_q;
   logic               rvalid0_q, rvalid1_q;
   logic               rd_issue;

   always_comb begin
      state_d = state_q;
      burst_d = burst_q;
      last_d  = last_q;
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      case (state_q)
         IDLE: begin
            // last_q=1 means m1 was served last, so m0 wins a tie
            if (m0_req_i && (!m1_req_i || last_q)) begin
               gnt0    = 1'b1;
               state_d = OWN0;
               burst_d = BURST_ONE;
            end else if (m1_req_i) begin
               gnt1    = 1'b1;
               state_d = OWN1;
               burst_d = BURST_ONE;
            end
         end
         OWN0: begin
            if (m0_req_i) begin
               gnt0 = 1'b1;
               if (m1_req_i && burst_q == BURST_LAST) begin
                  state_d = OWN1;
                  burst_d = '0;
                  last_d  = 1'b0;
               end else if (burst_q != BURST_LAST) begin
                  burst_d = burst_q + 1'b1;
               end
            end else if (m1_req_i) begin
               gnt1    = 1'b1;
               state_d = OWN1;
               burst_d = BURST_ONE;
               last_d  = 1'b0;
            end else begin
               state_d = IDLE;
               burst_d = '0;
               last_d  = 1'b0;
            end
         end
         OWN1: begin
            if (m1_req_i) begin
               gnt1 = 1'b1;
               if (m0_req_i && burst_q == BURST_LAST) begin
                  state_d = OWN0;
                  burst_d = '0;
                  last_d  = 1'b1;
               end else if (burst_q != BURST_LAST) begin
                  burst_d = burst_q + 1'b1;
               end
            end else if (m0_req_i) begin
               gnt0    = 1'b1;
               state_d = OWN0;
               burst_d = BURST_ONE;
               last_d  = 1'b1;
            end else begin
               state_d = IDLE;
               burst_d = '0;
               last_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            burst_d = '0;
         end
      endcase
      if (!rst_n) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
   end

   assign rd_issue = (gnt0 && !m0_we_i) || (gnt1 && !m1_we_i);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         burst_q   <= '0;
         last_q    <= 1'b1;
         ena_q     <= 1'b0;
         wea_q     <= 1'b0;
         addr_q    <= '0;
         dina_q    <= '0;
         tag_v_q   <= '0;
         tag_id_q  <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q <= state_d;
         burst_q <= burst_d;
         last_q  <= last_d;
         ena_q   <= gnt0 || gnt1;
         wea_q   <= (gnt0 && m0_we_i) || (gnt1 && m1_we_i);
         if (gnt0 || gnt1) begin
            addr_q <= gnt1 ? m1_addr_i  : m0_addr_i;
            dina_q <= gnt1 ? m1_wdata_i : m0_wdata_i;
         end
         // tag stage k describes the read whose command was on the BRAM k cycles ago
         tag_v_q   <= {tag_v_q[RD_LAT-1:0], rd_issue};
         tag_id_q  <= {tag_id_q[RD_LAT-1:0], gnt1};
         rvalid0_q <= tag_v_q[RD_LAT] && !tag_id_q[RD_LAT];
         rvalid1_q <= tag_v_q[RD_LAT] &&  tag_id_q[RD_LAT];
         if (tag_v_q[RD_LAT]) begin
            rdata_q <= douta_i;
         end
      end
   end

   assign m0_gnt_o    = gnt0;
   assign m1_gnt_o    = gnt1;
   assign ena_o       = ena_q;
   assign wea_o       = wea_q;
   assign addr_o      = addr_q;
   assign dina_o      = dina_q;
   assign rdata_o     = rdata_q;
   assign m0_rvalid_o = rvalid0_q;
   assign m1_rvalid_o = rvalid1_q;
   assign busy_o      = (state_q != IDLE);

`ifdef BRAM_ARB_STATS_EN
   logic [31:0] m0_gcnt_q, m1_gcnt_q, stall_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m0_gcnt_q   <= '0;
         m1_gcnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (gnt0 && m0_gcnt_q != 32'hFFFF_FFFF) m0_gcnt_q <= m0_gcnt_q + 1'b1;
         if (gnt1 && m1_gcnt_q != 32'hFFFF_FFFF) m1_gcnt_q <= m1_gcnt_q + 1'b1;
         if (((m0_req_i && !gnt0) || (m1_req_i && !gnt1)) && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

   assign m0_gcnt_o   = m0_gcnt_q;
   assign m1_gcnt_o   = m1_gcnt_q;
   assign stall_cnt_o = stall_cnt_q;
`else
   assign m0_gcnt_o   = '0;
   assign m1_gcnt_o   = '0;
   assign stall_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed self-checking bench for bram_arbiter with a 2-cycle BRAM model.
`default_nettype none

module tb_bram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        m0_req_i = 1'b0, m0_we_i = 1'b0;
   logic [18:0] m0_addr_i = '0;
   logic [7:0]  m0_wdata_i = '0;
   logic        m1_req_i = 1'b0, m1_we_i = 1'b0;
   logic [18:0] m1_addr_i = '0;
   logic [7:0]  m1_wdata_i = '0;
   logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
   logic [7:0]  rdata_o, dina_o;
   logic        ena_o, wea_o, busy_o;
   logic [18:0] addr_o;
   logic [7:0]  douta_i = '0;
   logic [31:0] m0_gcnt_o, m1_gcnt_o, stall_cnt_o;

   int n_tests = 0;
   int n_fail  = 0;

   bram_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
      .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
      .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
      .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
      .rdata_o(rdata_o), .ena_o(ena_o), .wea_o(wea_o), .addr_o(addr_o), .dina_o(dina_o),
      .douta_i(douta_i), .busy_o(busy_o),
      .m0_gcnt_o(m0_gcnt_o), .m1_gcnt_o(m1_gcnt_o), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk = ~clk;

   // BRAM model: unwritten locations hold addr ^ 0x3C; RD_LAT = 2
   logic [7:0] mem [0:1023];
   bit         wr_v [0:1023];
   logic [7:0] rd1 = '0;

   function automatic logic [7:0] init_val(input logic [9:0] a);
      return a[7:0] ^ 8'h3C;
   endfunction

   always @(posedge clk) begin
      if (ena_o && wea_o) begin
         mem[addr_o[9:0]]  = dina_o;
         wr_v[addr_o[9:0]] = 1'b1;
      end else if (ena_o) begin
         rd1 <= wr_v[addr_o[9:0]] ? mem[addr_o[9:0]] : init_val(addr_o[9:0]);
      end
      douta_i <= rd1;
   end

   task automatic drive_idle();
      m0_req_i = 1'b0; m0_we_i = 1'b0;
      m1_req_i = 1'b0; m1_we_i = 1'b0;
   endtask

   task automatic do_reset();
      drive_idle();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      n_tests++;
      if ({ena_o, wea_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, busy_o} !== 7'b0) begin
         n_fail++;
         $display("FAIL %s ctrl: got %b required 0000000", tag,
                  {ena_o, wea_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, busy_o});
      end
      n_tests++;
      if ({addr_o, dina_o, rdata_o} !== 35'b0) begin
         n_fail++;
         $display("FAIL %s data: addr %h dina %h rdata %h required 0", tag, addr_o, dina_o, rdata_o);
      end
      n_tests++;
      if ({m0_gcnt_o, m1_gcnt_o, stall_cnt_o} !== 96'b0) begin
         n_fail++;
         $display("FAIL %s stats: %h %h %h required 0", tag, m0_gcnt_o, m1_gcnt_o, stall_cnt_o);
      end
   endtask

   task automatic test_reset();
      drive_idle();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
   endtask

   task automatic test_m0_read();
      @(negedge clk);
      m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 19'h00010;
      #1;
      n_tests++;
      if ({m0_gnt_o, m1_gnt_o} !== 2'b10) begin
         n_fail++; $display("FAIL m0_read_gnt: got %b required 10", {m0_gnt_o, m1_gnt_o});
      end
      @(negedge clk);
      m0_req_i = 1'b0;
      #1;
      n_tests++;
      if ({ena_o, wea_o, busy_o, addr_o} !== {3'b101, 19'h00010}) begin
         n_fail++;
         $display("FAIL m0_read_cmd: ena/wea/busy %b addr %h required 101 00010", {ena_o, wea_o, busy_o}, addr_o);
      end
      for (int k = 2; k <= 5; k++) begin
         @(negedge clk);
         #1;
         n_tests++;
         if ({m0_rvalid_o, m1_rvalid_o} !== ((k == 4) ? 2'b10 : 2'b00)) begin
            n_fail++;
            $display("FAIL m0_read_rvalid T+%0d: got %b required %b", k, {m0_rvalid_o, m1_rvalid_o},
                     (k == 4) ? 2'b10 : 2'b00);
         end
         if (k >= 4) begin
            n_tests++;
            if (rdata_o !== 8'h2C) begin
               n_fail++; $display("FAIL m0_read_data T+%0d: got %h required 2c", k, rdata_o);
            end
         end
      end
   endtask

   task automatic test_m1_write_read();
      @(negedge clk);
      m1_req_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 19'h00005; m1_wdata_i = 8'hA5;
      #1;
      n_tests++;
      if ({m0_gnt_o, m1_gnt_o} !== 2'b01) begin
         n_fail++; $display("FAIL m1_write_gnt: got %b required 01", {m0_gnt_o, m1_gnt_o});
      end
      @(negedge clk);
      #1;
      n_tests++;
      if ({ena_o, wea_o, addr_o, dina_o} !== {2'b11, 19'h00005, 8'hA5}) begin
         n_fail++;
         $display("FAIL m1_write_cmd: ena/wea %b addr %h dina %h required 11 00005 a5", {ena_o, wea_o}, addr_o, dina_o);
      end
      m1_we_i = 1'b0;
      #1;
      n_tests++;
      if ({m0_gnt_o, m1_gnt_o} !== 2'b01) begin
         n_fail++; $display("FAIL m1_read_gnt: got %b required 01", {m0_gnt_o, m1_gnt_o});
      end
      @(negedge clk);
      m1_req_i = 1'b0;
      #1;
      n_tests++;
      if ({ena_o, wea_o} !== 2'b10) begin
         n_fail++; $display("FAIL m1_read_cmd: ena/wea %b required 10", {ena_o, wea_o});
      end
      for (int k = 2; k <= 5; k++) begin
         @(negedge clk);
         #1;
         n_tests++;
         if ({m0_rvalid_o, m1_rvalid_o} !== ((k == 4) ? 2'b01 : 2'b00)) begin
            n_fail++;
            $display("FAIL m1_rvalid T+%0d: got %b required %b", k, {m0_rvalid_o, m1_rvalid_o},
                     (k == 4) ? 2'b01 : 2'b00);
         end
         if (k == 4) begin
            n_tests++;
            if (rdata_o !== 8'hA5) begin
               n_fail++; $display("FAIL m1_read_data: got %h required a5", rdata_o);
            end
         end
      end
   endtask

   bit exp_rv0 [0:1299];
   bit exp_rv1 [0:1299];

   task automatic test_round_robin();
      int overlap = 0, sched_err = 0, route_err = 0, data_err = 0;
      int runs[$];
      int run_len = 0;
      logic run_id = 1'b0;
      logic eg0, eg1;
      do_reset();
      for (int i = 0; i < 1300; i++) begin
         exp_rv0[i] = 1'b0; exp_rv1[i] = 1'b0;
      end
      @(negedge clk);
      m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 19'h00020;
      m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 19'h00030;
      for (int c = 0; c < 1206; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 1200) drive_idle();
         #1;
         eg0 = (c < 540) || (c >= 1080 && c < 1200);
         eg1 = (c >= 540 && c < 1080);
         if (m0_gnt_o && m1_gnt_o) overlap++;
         if ({m0_gnt_o, m1_gnt_o} !== {eg0, eg1}) sched_err++;
         if (m0_gnt_o || m1_gnt_o) begin
            if (run_len > 0 && run_id == m1_gnt_o) begin
               run_len++;
            end else begin
               if (run_len > 0) runs.push_back(run_len);
               run_len = 1;
               run_id  = m1_gnt_o;
            end
            if (m0_gnt_o) exp_rv0[c + 4] = 1'b1;
            if (m1_gnt_o) exp_rv1[c + 4] = 1'b1;
         end
         if ({m0_rvalid_o, m1_rvalid_o} !== {exp_rv0[c], exp_rv1[c]}) route_err++;
         if (m0_rvalid_o && rdata_o !== 8'h1C) data_err++;
         if (m1_rvalid_o && rdata_o !== 8'h0C) data_err++;
      end
      if (run_len > 0) runs.push_back(run_len);
      n_tests++;
      if (overlap !== 0) begin
         n_fail++; $display("FAIL rr_overlap: %0d overlapping cycles required 0", overlap);
      end
      n_tests++;
      if (sched_err !== 0) begin
         n_fail++; $display("FAIL rr_schedule: %0d cycles off schedule required 0", sched_err);
      end
      n_tests++;
      if (route_err !== 0) begin
         n_fail++; $display("FAIL rr_rvalid_route: %0d misrouted cycles required 0", route_err);
      end
      n_tests++;
      if (data_err !== 0) begin
         n_fail++; $display("FAIL rr_rdata: %0d bad data beats required 0", data_err);
      end
      n_tests++;
      if (runs.size() !== 3) begin
         n_fail++; $display("FAIL rr_burst_count: %0d bursts required 3", runs.size());
      end else if (runs[0] !== 540 || runs[1] !== 540 || runs[2] !== 120) begin
         n_fail++;
         $display("FAIL rr_burst_len: got %0d,%0d,%0d required 540,540,120", runs[0], runs[1], runs[2]);
      end
   endtask

   task automatic test_stream();
      int err = 0;
      @(negedge clk);
      m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 19'h00020;
      for (int c = 0; c < 1000; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if ({m0_gnt_o, m1_gnt_o} !== 2'b10) err++;
      end
      n_tests++;
      if (err !== 0) begin
         n_fail++; $display("FAIL stream_m0: %0d cycles without m0 grant required 0", err);
      end
      @(negedge clk);
      m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 19'h00030;
      #1;
      n_tests++;
      if ({m0_gnt_o, m1_gnt_o} !== 2'b10) begin
         n_fail++; $display("FAIL stream_sat_last: got %b required 10", {m0_gnt_o, m1_gnt_o});
      end
      @(negedge clk);
      #1;
      n_tests++;
      if ({m0_gnt_o, m1_gnt_o} !== 2'b01) begin
         n_fail++; $display("FAIL stream_rotate: got %b required 01", {m0_gnt_o, m1_gnt_o});
      end
      @(negedge clk);
      drive_idle();
      repeat (6) @(negedge clk);
   endtask

   task automatic test_drop_mid_burst();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c == 0) begin m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 19'h00040; end
         if (c == 2) begin m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 19'h00050; end
         if (c == 5) m0_req_i = 1'b0;
         #1;
         n_tests++;
         if ({m0_gnt_o, m1_gnt_o} !== ((c < 5) ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("FAIL drop_gnt c%0d: got %b required %b", c, {m0_gnt_o, m1_gnt_o},
                     (c < 5) ? 2'b10 : 2'b01);
         end
      end
      @(negedge clk);
      #1;
      n_tests++;
      if ({ena_o, wea_o, addr_o} !== {2'b10, 19'h00050}) begin
         n_fail++;
         $display("FAIL drop_no_bubble: ena/wea %b addr %h required 10 00050", {ena_o, wea_o}, addr_o);
      end
      drive_idle();
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int err = 0;
      @(negedge clk);
      m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 19'h00010;
      #1;
      n_tests++;
      if ({m0_gnt_o, m1_gnt_o} !== 2'b10) begin
         n_fail++; $display("FAIL rstmid_gnt: got %b required 10", {m0_gnt_o, m1_gnt_o});
      end
      @(negedge clk);
      m0_req_i = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      check_all_zero("rstmid");
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         #1;
         if ({m0_rvalid_o, m1_rvalid_o} !== 2'b00 || rdata_o !== 8'h00) err++;
      end
      n_tests++;
      if (err !== 0) begin
         n_fail++; $display("FAIL rstmid_discard: %0d cycles with rvalid/rdata required 0", err);
      end
   endtask

   initial begin
      test_reset();
      test_m0_read();
      test_m1_write_read();
      test_round_robin();
      test_stream();
      test_drop_mid_burst();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Shares the single-port 540x540 frame BRAM between two requesters.
- Requester 0 is the mode-1 display read path. Requester 1 is the Sobel fetch/write-back path.
- Sits between the memory/fetch logic and the BRAM instance. Registers every BRAM command and returns read data tagged to the requester that issued it.
- Guarantees fair round-robin sharing, with a bounded burst length per owner.

Parameters:
ADDR_W, 19, BRAM address width
DATA_W, 8, pixel/data width
RD_LAT, 2, BRAM read latency in cycles, from command-register cycle to douta valid (legal 1..4)
MAX_BURST, 540, max consecutive grants to one owner while the other requester is pending (one image row)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
m0_req_i  in  1  requester 0 access request
m0_we_i  in  1  requester 0 write enable (1=write, 0=read)
m0_addr_i  in  ADDR_W  requester 0 address
m0_wdata_i  in  DATA_W  requester 0 write data
m0_gnt_o  out  1  requester 0 grant; command accepted this cycle
m0_rvalid_o  out  1  rdata_o valid for requester 0
m1_req_i  in  1  requester 1 access request
m1_we_i  in  1  requester 1 write enable
m1_addr_i  in  ADDR_W  requester 1 address
m1_wdata_i  in  DATA_W  requester 1 write data
m1_gnt_o  out  1  requester 1 grant
m1_rvalid_o  out  1  rdata_o valid for requester 1
rdata_o  out  DATA_W  shared read data, registered copy of douta_i
ena_o  out  1  BRAM enable
wea_o  out  1  BRAM write enable
addr_o  out  ADDR_W  BRAM address
dina_o  out  DATA_W  BRAM write data
douta_i  in  DATA_W  BRAM read data
busy_o  out  1  state != IDLE
- Clock and reset: clk, rst_n; reset is synchronous and active-low.

Behaviour:
- Reset, sampled on the clk edge with rst_n=0:
  - All outputs 0; state=IDLE; burst counter=0; last-served=1, so m0 wins the first tie.
  - Read-tag pipeline cleared.
- Handshake:
  - A requester holds req/we/addr/wdata stable until it sees gnt in the same cycle.
  - gnt is combinational from req_i and registered state; at most one gnt per cycle.
  - A requester may hold req high across cycles to stream one access per cycle.
- Command path:
  - Granted command is registered into ena_o/wea_o/addr_o/dina_o on the next edge.
  - ena_o=0 and wea_o=0 in cycles with no grant.
- Read return:
  - A read granted in cycle T gives mN_rvalid_o=1 with rdata_o in cycle T+1+RD_LAT+1.
  - That is one command-register cycle, RD_LAT BRAM cycles, and one rdata register cycle; T+4 with defaults.
  - Implemented as a (RD_LAT+1)-deep shift register of {valid, id}. Writes produce no rvalid.
  - rdata_o holds its last value when no rvalid is asserted.
- FSM states: IDLE, OWN0, OWN1.
  - IDLE: if only one req, grant it and go to OWNn. If both, grant the requester not last-served and go to its OWN state. If none, stay.
  - OWNn, own req high, and (other req low or burst_cnt < MAX_BURST-1): grant n, burst_cnt++, stay.
  - OWNn, own req high, other req high, burst_cnt == MAX_BURST-1: grant n this cycle (the MAX_BURST-th grant), then move to OWN(other) with burst_cnt=0 and last-served=n. The other requester is granted from the next cycle.
  - OWNn, own req low: if other req high, grant other this cycle and go to OWN(other). Else go to IDLE and set last-served=n.
- burst_cnt width is clog2(MAX_BURST); it saturates at MAX_BURST-1 while no other requester is pending.
- Simultaneous requests in IDLE resolve by round-robin. No requester waits more than MAX_BURST grants.
- Reset mid-operation:
  - In-flight reads are discarded with no rvalid; the BRAM command is dropped.
  - Requesters must reissue.

Optional Feature:
BRAM_ARB_STATS_EN
- Defined: adds three 32-bit saturating counters, readable on ports m0_gcnt_o, m1_gcnt_o and stall_cnt_o.
  - m0_gcnt_o counts grants to requester 0; m1_gcnt_o counts grants to requester 1.
  - stall_cnt_o counts cycles with a req high and its gnt low.
  - Counters clear on reset and saturate at 0xFFFFFFFF.
- Not defined: the same ports exist and are tied to 0; no counter logic.

Test Plan:
- Reset, then m0 read only, addr=0x00010 -> m0_gnt_o same cycle; addr_o=0x00010, ena_o=1, wea_o=0 next cycle; m0_rvalid_o at T+4 with rdata_o = BRAM[0x10].
- m1 write addr=0x00005 data=0xA5, then m1 read of the same address -> no rvalid for the write; the read returns 0xA5 at T+4.
- Both req high from IDLE after reset -> m0 granted first. Both hold req for 1200 cycles:
  - grants alternate in bursts of exactly 540, 540, 120;
  - no gnt overlap;
  - every rvalid is routed to the correct requester.
- m0 streams with m1 idle for 1000 cycles -> m0 granted every cycle; burst counter saturates; no forced rotation.
- m0 drops req mid-burst while m1 pending -> m1 granted in that same cycle; no idle bubble.
- rst_n=0 one cycle after a read grant -> no rvalid ever appears; all outputs 0 on the next cycle. With BRAM_ARB_STATS_EN, counters read 0.
